// File: rtl/hazard_ctrl_v2_if.sv
// Hazard controller bus: datapath hazard inputs in one direction, stall/flush/forward controls in the other.
interface hazard_ctrl_v2_if #(
    parameter int REG_WIDTH = 4
);
    logic [REG_WIDTH-1:0] rsD, rtD, rsE, rtE;
    logic [REG_WIDTH-1:0] WriteRegE, WriteRegM, WriteRegW, rtM;
    logic                 RegWriteM, RegWriteW, MemReadE, MemWriteM;
    logic                 PCSrc, jump, md_startE, stop;
    logic [1:0]           alu_src1, alu_src2;
    logic                 mem_src;
    logic                 pcstall, IF_IDstall, ID_EXstall, EX_MEMstall, MEM_WBstall;
    logic                 flushIF_ID, flushID_EX, flushEX_MEM;
    logic [1:0]           busy_state;

    // Controller side
    modport slave (
        input  rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW, rtM,
               RegWriteM, RegWriteW, MemReadE, MemWriteM,
               PCSrc, jump, md_startE, stop,
        output alu_src1, alu_src2, mem_src,
               pcstall, IF_IDstall, ID_EXstall, EX_MEMstall, MEM_WBstall,
               flushIF_ID, flushID_EX, flushEX_MEM, busy_state
    );

    // Datapath side
    modport master (
        output rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW, rtM,
               RegWriteM, RegWriteW, MemReadE, MemWriteM,
               PCSrc, jump, md_startE, stop,
        input  alu_src1, alu_src2, mem_src,
               pcstall, IF_IDstall, ID_EXstall, EX_MEMstall, MEM_WBstall,
               flushIF_ID, flushID_EX, flushEX_MEM, busy_state
    );
endinterface

// File: rtl/hazard_ctrl_v2.sv
// 5-stage pipeline hazard controller: operand/store forwarding, load-use interlock,
// branch flush sequencer and mul/div stall sequencer sharing one down-counter.
module hazard_ctrl_v2 #(
    parameter int REG_WIDTH           = 4,
    parameter int BRANCH_FLUSH_CYCLES = 3,
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int MD_LATENCY          = 4
) (
    input  logic           clk,
    input  logic           rst,
    hazard_ctrl_v2_if.slave hif
);
    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] BR_FLUSH = 2'b01;
    localparam logic [1:0] LD_STALL = 2'b10;
    localparam logic [1:0] MD_WAIT  = 2'b11;

    localparam logic [REG_WIDTH-1:0] R0 = '0;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [1:0] alu_src1, alu_src2;
    logic       mem_src, load_use;
    logic       pcstall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic       flush_if_id, flush_id_ex, flush_ex_mem;

    // MEM result wins over WB; r0 is never forwarded
    function automatic logic [1:0] fwd_sel(input logic [REG_WIDTH-1:0] src,
                                           input logic [REG_WIDTH-1:0] wr_m,
                                           input logic                 we_m,
                                           input logic [REG_WIDTH-1:0] wr_w,
                                           input logic                 we_w);
        if (src != R0 && we_m && wr_m == src)      return 2'b01;
        else if (src != R0 && we_w && wr_w == src) return 2'b10;
        else                                       return 2'b00;
    endfunction

    // Forwarding selects; forced to regfile while in reset
    always_comb begin
        alu_src1 = 2'b00;
        alu_src2 = 2'b00;
        mem_src  = 1'b0;
        if (!rst) begin
            alu_src1 = fwd_sel(hif.rsE, hif.WriteRegM, hif.RegWriteM, hif.WriteRegW, hif.RegWriteW);
            alu_src2 = fwd_sel(hif.rtE, hif.WriteRegM, hif.RegWriteM, hif.WriteRegW, hif.RegWriteW);
            mem_src  = (hif.rtM != R0) && hif.MemWriteM && hif.RegWriteW &&
                       (hif.WriteRegW == hif.rtM);
        end
    end

    assign load_use = hif.MemReadE && (hif.WriteRegE != R0) &&
                      ((hif.WriteRegE == hif.rsD) || (hif.WriteRegE == hif.rtD));

    // Sequencer next-state and Mealy stall/flush outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pcstall      = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (rst) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else if (hif.stop) begin
            // Whole pipe frozen; sequencer state held as-is
            pcstall      = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hif.PCSrc) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        if (BRANCH_FLUSH_CYCLES > 1) begin
                            state_d = BR_FLUSH;
                            cnt_d   = 4'(BRANCH_FLUSH_CYCLES - 1);
                        end
                    end else if (hif.md_startE) begin
                        pcstall      = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        flush_ex_mem = 1'b1;
                        if (MD_LATENCY > 1) begin
                            state_d = MD_WAIT;
                            cnt_d   = 4'(MD_LATENCY - 1);
                        end
                    end else if (load_use) begin
                        pcstall     = 1'b1;
                        if_id_stall = 1'b1;
                        flush_id_ex = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LD_STALL;
                            cnt_d   = 4'(LOAD_STALL_CYCLES - 1);
                        end
                    end else if (hif.jump) begin
                        flush_if_id = 1'b1;
                    end
                end
                BR_FLUSH: begin
                    // Wrong-path events ignored until the flush drains
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
                LD_STALL: begin
                    pcstall     = 1'b1;
                    if_id_stall = 1'b1;
                    flush_id_ex = 1'b1;
                end
                default: begin // MD_WAIT
                    pcstall      = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    flush_ex_mem = 1'b1;
                end
            endcase
            if (state_q != IDLE) begin
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        end
    end

    // State and shared counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hif.alu_src1    = alu_src1;
    assign hif.alu_src2    = alu_src2;
    assign hif.mem_src     = mem_src;
    assign hif.pcstall     = pcstall;
    assign hif.IF_IDstall  = if_id_stall;
    assign hif.ID_EXstall  = id_ex_stall;
    assign hif.EX_MEMstall = ex_mem_stall;
    assign hif.MEM_WBstall = mem_wb_stall;
    assign hif.flushIF_ID  = flush_if_id;
    assign hif.flushID_EX  = flush_id_ex;
    assign hif.flushEX_MEM = flush_ex_mem;
    assign hif.busy_state  = state_q;
endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// Directed-vector bench for hazard_ctrl_v2 (LOAD_STALL_CYCLES=2, other parameters default).
module tb_hazard_ctrl_v2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    hazard_ctrl_v2_if #(.REG_WIDTH(4)) hif ();

    hazard_ctrl_v2 #(
        .REG_WIDTH(4), .BRANCH_FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(2), .MD_LATENCY(4)
    ) dut (
        .clk(clk), .rst(rst), .hif(hif)
    );

    // {pcstall, IF_ID, ID_EX, EX_MEM, MEM_WB stalls, flushIF_ID, flushID_EX, flushEX_MEM}
    logic [7:0] ctl;
    assign ctl = {hif.pcstall, hif.IF_IDstall, hif.ID_EXstall, hif.EX_MEMstall, hif.MEM_WBstall,
                  hif.flushIF_ID, hif.flushID_EX, hif.flushEX_MEM};

    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_BR   = 8'b0000_0110;
    localparam logic [7:0] C_LD   = 8'b1100_0010;
    localparam logic [7:0] C_JMP  = 8'b0000_0100;
    localparam logic [7:0] C_MD   = 8'b1110_0001;
    localparam logic [7:0] C_STOP = 8'b1111_1000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and checks happen shortly after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cyc(input string tag, input logic [7:0] c, input logic [1:0] st);
        #1;
        chk({tag, ".ctl"}, 32'(ctl), 32'(c));
        chk({tag, ".st"},  32'(hif.busy_state), 32'(st));
    endtask

    initial begin
        {hif.rsD, hif.rtD, hif.rsE, hif.rtE, hif.WriteRegE, hif.WriteRegM, hif.WriteRegW, hif.rtM} = '0;
        {hif.RegWriteM, hif.RegWriteW, hif.MemReadE, hif.MemWriteM} = '0;
        {hif.PCSrc, hif.jump, hif.md_startE, hif.stop} = '0;

        // Reset overrides a branch and live forwarding conditions
        tick(); tick();
        hif.PCSrc = 1'b1; hif.rsE = 4'd3; hif.WriteRegM = 4'd3; hif.RegWriteM = 1'b1;
        chk_cyc("rst", C_NONE, 2'b00);
        chk("rst.fwd1", 32'(hif.alu_src1), 32'd0);
        tick();
        rst = 1'b0; hif.PCSrc = 1'b0; hif.RegWriteM = 1'b0; hif.rsE = 4'd0;

        // Forwarding
        hif.rsE = 4'd3; hif.rtE = 4'd3; hif.WriteRegM = 4'd3; hif.RegWriteM = 1'b1;
        hif.WriteRegW = 4'd3; hif.RegWriteW = 1'b1; #1;
        chk("fwd1.mem", 32'(hif.alu_src1), 32'd1);
        chk("fwd2.mem", 32'(hif.alu_src2), 32'd1);
        hif.RegWriteM = 1'b0; #1;
        chk("fwd1.wb",  32'(hif.alu_src1), 32'd2);
        hif.rsE = 4'd0; #1;
        chk("fwd1.r0",  32'(hif.alu_src1), 32'd0);
        chk("fwd2.wb",  32'(hif.alu_src2), 32'd2);
        hif.rtE = 4'd7; #1;
        chk("fwd2.none", 32'(hif.alu_src2), 32'd0);
        hif.rtM = 4'd5; hif.WriteRegW = 4'd5; hif.MemWriteM = 1'b1; #1;
        chk("memsrc",   32'(hif.mem_src), 32'd1);
        hif.rtM = 4'd0; hif.WriteRegW = 4'd0; #1;
        chk("memsrc.r0", 32'(hif.mem_src), 32'd0);
        {hif.RegWriteW, hif.MemWriteM, hif.rtE} = '0;

        // Plain jump in IDLE
        tick(); hif.jump = 1'b1; chk_cyc("jmp", C_JMP, 2'b00);
        tick(); hif.jump = 1'b0;

        // Branch, depth 3, second PCSrc ignored
        hif.PCSrc = 1'b1; chk_cyc("br0", C_BR, 2'b00);
        tick();           chk_cyc("br1", C_BR, 2'b01);
        tick(); hif.PCSrc = 1'b0; chk_cyc("br2", C_BR, 2'b01);
        tick();           chk_cyc("br3", C_NONE, 2'b00);

        // Load-use, 2 bubbles, jump held in ID
        tick(); hif.MemReadE = 1'b1; hif.WriteRegE = 4'd4; hif.rtD = 4'd4; hif.jump = 1'b1;
        chk_cyc("ld0", C_LD, 2'b00);
        tick(); hif.MemReadE = 1'b0; chk_cyc("ld1", C_LD, 2'b10);
        tick(); chk_cyc("ld2", C_JMP, 2'b00);
        tick(); hif.jump = 1'b0; hif.WriteRegE = 4'd0; hif.MemReadE = 1'b1;
        chk_cyc("ld.r0", C_NONE, 2'b00);
        hif.MemReadE = 1'b0; hif.rtD = 4'd0;

        // Mul/div, latency 4
        tick(); hif.md_startE = 1'b1; chk_cyc("md0", C_MD, 2'b00);
        tick(); hif.md_startE = 1'b0; chk_cyc("md1", C_MD, 2'b11);
        tick(); chk_cyc("md2", C_MD, 2'b11);
        tick(); chk_cyc("md3", C_MD, 2'b11);
        tick(); chk_cyc("md4", C_NONE, 2'b00);

        // Stop during MD_WAIT with cnt=2; branch during stop is masked
        tick(); hif.md_startE = 1'b1; chk_cyc("sm0", C_MD, 2'b00);
        tick(); hif.md_startE = 1'b0; chk_cyc("sm1", C_MD, 2'b11);
        for (int i = 0; i < 5; i++) begin
            tick(); hif.stop = 1'b1; hif.PCSrc = (i == 2);
            chk_cyc($sformatf("stop%0d", i), C_STOP, 2'b11);
        end
        tick(); hif.stop = 1'b0; hif.PCSrc = 1'b0; chk_cyc("sm2", C_MD, 2'b11);
        tick(); chk_cyc("sm3", C_MD, 2'b11);
        tick(); chk_cyc("sm4", C_NONE, 2'b00);

        // Reset aborts a branch flush
        tick(); hif.PCSrc = 1'b1; chk_cyc("rb0", C_BR, 2'b00);
        tick(); hif.PCSrc = 1'b0; rst = 1'b1; chk_cyc("rb1", C_NONE, 2'b01);
        tick(); rst = 1'b0; chk_cyc("rb2", C_NONE, 2'b00);
        tick(); chk_cyc("rb3", C_NONE, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_v2.md
Name: hazard_ctrl_v2

Overview:
Parametrised successor hazard controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It provides EX-operand and store-data forwarding selects, and a multi-cycle load-use interlock. It adds a branch flush sequencer with programmable depth and a multi-cycle mul/div stall sequencer. It sits beside the datapath and drives every pipeline-register stall/flush and the PC stall.

Parameters:
REG_WIDTH, 4, register-index width
BRANCH_FLUSH_CYCLES, 3, total cycles (incl. detection cycle) flush asserted after taken branch; legal 1..7
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal 1..7
MD_LATENCY, 4, cycles mul/div occupies EX; legal 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rsD, rtD  in  REG_WIDTH  source regs of instr in ID
rsE, rtE  in  REG_WIDTH  source regs of instr in EX
WriteRegE, WriteRegM, WriteRegW  in  REG_WIDTH  destination reg per stage
RegWriteM, RegWriteW  in  1  write-enable per stage
MemReadE  in  1  load in EX
rtM  in  REG_WIDTH  store-data reg in MEM
MemWriteM  in  1  store in MEM
PCSrc  in  1  taken branch resolved in EX
jump  in  1  jump decoded in ID
md_startE  in  1  mul/div instr entering EX (1-cycle pulse)
stop  in  1  global halt
alu_src1, alu_src2  out  2  forward select: 00 regfile, 01 MEM, 10 WB
mem_src  out  1  store data from WB result
pcstall, IF_IDstall, ID_EXstall, EX_MEMstall, MEM_WBstall  out  1  hold enables
flushIF_ID, flushID_EX, flushEX_MEM  out  1  bubble-insert enables
busy_state  out  2  FSM state (debug)

Behaviour:
- Forwarding (combinational): alu_src1=01 if rsE!=0 & RegWriteM & WriteRegM==rsE; else 10 if rsE!=0 & RegWriteW & WriteRegW==rsE; else 00. MEM has priority over WB. alu_src2 is identical using rtE. mem_src=1 iff rtM!=0 & MemWriteM & RegWriteW & WriteRegW==rtM.
- FSM states: IDLE=00, BR_FLUSH=01, LD_STALL=10, MD_WAIT=11. One shared 4-bit down-counter cnt.
- Priority each cycle: rst > stop > PCSrc > md_startE > load-use > jump.
- rst: next state IDLE, cnt=0. All stall/flush outputs 0 and alu_src1/alu_src2=00 while rst is high. Reset mid-sequence aborts the sequence immediately.
- stop: all five stalls=1, all flushes=0. State and cnt frozen. Forwarding outputs remain live.
- IDLE, PCSrc=1: flushIF_ID=1 and flushID_EX=1 this cycle. If BRANCH_FLUSH_CYCLES>1, go to BR_FLUSH with cnt=BRANCH_FLUSH_CYCLES-1.
- BR_FLUSH: flushIF_ID=flushID_EX=1 and cnt decrements each cycle. Leave to IDLE on the cycle cnt==1. PCSrc, md_startE, jump and load-use are ignored (wrong-path).
- IDLE, md_startE=1: pcstall=IF_IDstall=ID_EXstall=1 and flushEX_MEM=1. Go to MD_WAIT with cnt=MD_LATENCY-1 if MD_LATENCY>1. MD_WAIT holds the same outputs until cnt reaches 1, then returns to IDLE. The result advances on the cycle after the last stall.
- IDLE, load-use: MemReadE & WriteRegE!=0 & (WriteRegE==rsD | WriteRegE==rtD). Assert pcstall=IF_IDstall=1 and flushID_EX=1. If LOAD_STALL_CYCLES>1, go to LD_STALL with cnt=LOAD_STALL_CYCLES-1 and hold the same outputs until cnt==1.
- jump (IDLE, no higher-priority event): flushIF_ID=1 for exactly that cycle. A jump during any stall is suppressed and re-evaluated once ID is released.
- Default outputs: 0. Outputs are a function of state, cnt and current inputs (Mealy for the detection cycle), so there is no extra latency.

Test Plan:
- Forwarding: rsE=3, WriteRegM=3, RegWriteM=1, WriteRegW=3, RegWriteW=1 -> alu_src1=01. Repeat with RegWriteM=0 -> 10. Repeat with rsE=0 -> 00. Store with rtM=5, WriteRegW=5, RegWriteW=1, MemWriteM=1 -> mem_src=1.
- Branch, default depth: PCSrc pulse at cycle t -> flushIF_ID=flushID_EX=1 for cycles t..t+2, 0 at t+3. A second PCSrc at t+1 is ignored and the sequence still ends at t+3.
- Load-use, LOAD_STALL_CYCLES=2: MemReadE=1, WriteRegE=4, rtD=4 -> pcstall/IF_IDstall/flushID_EX high for exactly 2 cycles. A jump held in ID gives flushIF_ID=0 during the stall and 1 on the first released cycle.
- Mul/div, MD_LATENCY=4: md_startE pulse -> pcstall/IF_IDstall/ID_EXstall/flushEX_MEM high for 4 cycles, busy_state=11 for 3 of them, then IDLE.
- stop mid-MD_WAIT with cnt=2: stop high for 5 cycles -> all stalls=1, flushes=0, cnt frozen. After stop drops, the remaining 2 MD cycles complete.
- rst asserted in BR_FLUSH -> the next cycle is IDLE, all outputs 0, busy_state=00.
